// File: rtl/conv_group_sched_pkg.sv
// Shared widths, state encoding and in-flight tag layout for the group-sum sequencer.
package conv_group_sched_pkg;
  localparam int DATA_INTER_WIDTH    = 20;
  localparam int CONV_TREE_LAT       = 2;
  localparam int CONV_SUM_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic v;
    logic first;
    logic last_grp;
    logic last_pix;
  } grp_tag_t;
endpackage

// File: rtl/conv_group_sched_if.sv
// Operand/sum stream from the adder tree and the pixel output stream.
interface conv_group_sched_if;
  import conv_group_sched_pkg::*;

  logic                        src_valid;
  logic                        src_ready;
  logic [DATA_INTER_WIDTH-1:0] sum_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_INTER_WIDTH-1:0] out_data;
  logic                        out_last;

  modport slave (
    input  src_valid, sum_data, out_ready,
    output src_ready, out_valid, out_data, out_last
  );

  modport master (
    output src_valid, sum_data, out_ready,
    input  src_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/conv_sum_fifo.sv
// Small synchronous FIFO whose head word and valid flag are held in flops.
module conv_sum_fifo #(
  parameter  int WIDTH = 21,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             w_pop;
  logic [AW-1:0]    w_rd_next;
  logic [CW-1:0]    w_remain, w_count_next;

  always_comb begin
    w_pop        = i_pop & r_valid;
    w_rd_next    = r_rd_ptr + AW'(w_pop);
    w_remain     = r_count - CW'(w_pop);
    w_count_next = w_remain + CW'(i_push);
  end

  // Head register reloads from storage, or straight from the push when nothing older remains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_data   <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      if (w_remain != '0) r_data <= r_mem[w_rd_next];
      else if (i_push)    r_data <= i_push_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_count = r_count;
endmodule

// File: rtl/conv_group_sched.sv
// Issues group operands into the adder tree, accumulates per-pixel sums and queues finished pixels.
module conv_group_sched
  import conv_group_sched_pkg::*;
#(
  parameter int TREE_LAT   = CONV_TREE_LAT,
  parameter int FIFO_DEPTH = CONV_SUM_FIFO_DEPTH,
  parameter int GRP_W      = 8,
  parameter int PIX_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [GRP_W-1:0] i_cfg_groups,
  input  logic [PIX_W-1:0] i_cfg_pixels,
  output logic             o_busy,
  output logic             o_done,
  conv_group_sched_if.slave bus
);
  localparam int W   = DATA_INTER_WIDTH;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CW1 = CW + 1;

  sched_state_t     r_state, w_state_next;
  logic [GRP_W-1:0] r_cfg_groups, r_grp_cnt;
  logic [PIX_W-1:0] r_cfg_pixels, r_pix_issued;
  logic [CW-1:0]    r_pix_inflight;
  grp_tag_t         r_tag [TREE_LAT];
  logic [W-1:0]     r_acc;
  logic             r_busy, r_done;

  logic             w_done_next, w_src_ready, w_issue;
  logic             w_first, w_last_grp, w_last_pix, w_push, w_pop_last;
  grp_tag_t         w_arr;
  logic [W-1:0]     w_sum;
  logic [CW-1:0]    w_fifo_count;
  logic [CW1-1:0]   w_credit_used;
  logic             w_fifo_valid;
  logic [W:0]       w_fifo_data;

  // A new pixel may only start when a FIFO slot is still unclaimed.
  always_comb begin
    w_first       = (r_grp_cnt == '0);
    w_last_grp    = (r_grp_cnt == r_cfg_groups - GRP_W'(1));
    w_last_pix    = (r_pix_issued == r_cfg_pixels - PIX_W'(1));
    w_credit_used = CW1'(w_fifo_count) + CW1'(r_pix_inflight);
    w_src_ready   = (r_state == ST_RUN) && (r_pix_issued < r_cfg_pixels) &&
                    (!w_first || (w_credit_used < CW1'(FIFO_DEPTH)));
    w_issue       = bus.src_valid & w_src_ready;
    w_arr         = r_tag[TREE_LAT-1];
    w_sum         = w_arr.first ? bus.sum_data : r_acc + bus.sum_data;
    w_push        = w_arr.v & w_arr.last_grp;
    w_pop_last    = w_fifo_valid & bus.out_ready & w_fifo_data[W];
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if ((i_cfg_groups == '0) || (i_cfg_pixels == '0)) w_done_next  = 1'b1;
          else                                              w_state_next = ST_RUN;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_issue && w_last_grp && w_last_pix) w_state_next = ST_DRAIN;
        else                                     w_state_next = ST_RUN;
      end
      ST_DRAIN: begin
        if (w_pop_last) begin
          w_state_next = ST_IDLE;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = ST_DRAIN;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != ST_IDLE);
      r_done  <= w_done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cfg_groups   <= '0;
      r_cfg_pixels   <= '0;
      r_grp_cnt      <= '0;
      r_pix_issued   <= '0;
      r_pix_inflight <= '0;
    end else begin
      if ((r_state == ST_IDLE) && i_start) begin
        r_cfg_groups <= i_cfg_groups;
        r_cfg_pixels <= i_cfg_pixels;
        r_grp_cnt    <= '0;
        r_pix_issued <= '0;
      end else if (w_issue) begin
        if (w_last_grp) begin
          r_grp_cnt    <= '0;
          r_pix_issued <= r_pix_issued + PIX_W'(1);
        end else begin
          r_grp_cnt <= r_grp_cnt + GRP_W'(1);
        end
      end
      r_pix_inflight <= r_pix_inflight + CW'(w_issue & w_first) - CW'(w_push);
    end
  end

  // Tag pipeline mirrors the tree so the last stage lines up with sum_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TREE_LAT; i++) r_tag[i] <= '0;
      r_acc <= '0;
    end else begin
      r_tag[0] <= {w_issue, w_first, w_last_grp, w_last_pix};
      for (int i = 1; i < TREE_LAT; i++) r_tag[i] <= r_tag[i-1];
      if (w_arr.v) r_acc <= w_sum;
    end
  end

  conv_sum_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data ({w_arr.last_pix, w_sum}),
    .i_pop       (bus.out_ready),
    .o_valid     (w_fifo_valid),
    .o_data      (w_fifo_data),
    .o_count     (w_fifo_count)
  );

  assign bus.src_ready = w_src_ready;
  assign bus.out_valid = w_fifo_valid;
  assign bus.out_data  = w_fifo_data[W-1:0];
  assign bus.out_last  = w_fifo_data[W];
  assign o_busy        = r_busy;
  assign o_done        = r_done;
endmodule
